traffic_conflict_monitor: RTL and testbench
===========================================

// Module: traffic_conflict_monitor
// PURPOSE
//  Safety stage directly downstream of the traffic light controller FSM. It samples the four
//  light buses (M1, M2, MT, S) and passes them to the lamp drivers. It checks encoding,
//  conflicting greens, G->Y->R sequencing, minimum yellow time and stuck heads. On the first
//  violation it latches a fault code and forces all heads to flashing red until cleared.
//  Light encoding: 3'b001 green, 3'b010 yellow, 3'b100 red.
// PARAMETERS
//  MIN_YEL     2   min consecutive yellow cycles before a head may go red
//  MAX_HOLD    32  max cycles a head may keep one value (watchdog); >= longest legal hold
//  FLASH_HALF  4   cycles per on/off half-period of the flashing-red failsafe
//  ALLRED      4   solid all-red cycles after reset or after fault clear, before NORMAL
// PORTS
//  clk          in   1  clock
//  rst          in   1  reset, asynchronous, active-high
//  light_M1_in  in   3  controller output, main road 1
//  light_M2_in  in   3  controller output, main road 2
//  light_MT_in  in   3  controller output, main-road turn
//  light_S_in   in   3  controller output, side road
//  fault_clr    in   1  operator clear; honoured only in FLASH
//  lamp_M1/M2/MT/S out 3  registered lamp drives, same encoding as inputs
//  fault        out  1  1 while a fault is latched (FLASH state)
//  fault_code   out  3  0 none, 1 ENC, 2 CONFLICT, 3 SEQ, 4 YEL, 5 HOLD
//  mon_ok       out  1  1 in NORMAL state
// BEHAVIOUR
//  Reset (async): state=INIT_RED, all lamps 3'b100, fault=0, fault_code=0, mon_ok=0,
//    all counters 0. Reset asserted mid-operation takes effect immediately.
//  Input stage: inputs registered into in_q every edge. Checks run combinationally on in_q
//    versus prev_q (in_q of the previous cycle).
//  States: INIT_RED -> NORMAL -> FLASH -> INIT_RED.
//  INIT_RED: lamps 3'b100. After ALLRED cycles, go to NORMAL. All checks are disabled here.
//  NORMAL: lamp <= in_q when no violation is detected. Input-to-lamp latency is 2 edges.
//    If a violation is detected: lamp <= 3'b100 on that edge, state <= FLASH, fault <= 1,
//    fault_code <= code. A violating value never reaches the lamps.
//  First NORMAL cycle: prev_q loaded, hold/yellow counters cleared, transition checks skipped.
//  Checks, by head. When several fire in one cycle, the lowest code wins:
//    1 ENC: an in_q value is not exactly one-hot.
//    2 CONFLICT: S non-red while any of M1/M2/MT is non-red; or MT and M2 both non-red.
//    3 SEQ: value changed and the change is not G->Y, Y->R or R->G.
//    4 YEL: Y->R change with yellow count < MIN_YEL.
//    5 HOLD: per-head unchanged counter reaches MAX_HOLD.
//  Counters: yellow counter counts consecutive yellow cycles. Hold counter clears on any
//    change. Both are 8-bit and saturating.
//  FLASH: lamps alternate 3'b100 for FLASH_HALF cycles, then 3'b000 for FLASH_HALF cycles,
//    starting with red on entry. fault_code is held and checks are disabled.
//  fault_clr in FLASH: next edge state=INIT_RED, fault=0, fault_code=0, lamps 3'b100.
//  fault_clr in any other state: ignored.
//  mon_ok is registered and is 1 exactly when state is NORMAL.
// TESTING
//  1 Reset, then drive a legal 28-cycle sequence x3 -> 4 all-red cycles, then lamps equal
//    inputs delayed 2 edges; fault=0 throughout.
//  2 In NORMAL, drive M1=001 and S=001 together -> lamps never show S=001; fault=1,
//    fault_code=2; flash sequence 100 x4, 000 x4, repeating.
//  3 Drive M2=3'b011 together with an MT/M2 conflict -> fault_code=1 (priority check).
//  4 M1 001->100 directly -> code 3. Separately, M1 yellow for 1 cycle then red -> code 4.
//  5 Freeze all inputs for 32 cycles in NORMAL -> code 5 on the 32nd unchanged cycle.
//  6 In FLASH: pulse fault_clr -> 4 cycles all red, then NORMAL, mon_ok=1. Assert rst
//    mid-FLASH -> lamps 100 and fault 0 immediately, with no clock edge.

Source files
------------

// File: rtl/traffic_conflict_monitor_if.sv
// Light/lamp bus between the controller FSM, the conflict monitor and the lamp drivers.
// master = controller/observer side, slave = the monitor.
interface traffic_conflict_monitor_if;
  logic [2:0] light_M1_in;
  logic [2:0] light_M2_in;
  logic [2:0] light_MT_in;
  logic [2:0] light_S_in;
  logic       fault_clr;
  logic [2:0] lamp_M1;
  logic [2:0] lamp_M2;
  logic [2:0] lamp_MT;
  logic [2:0] lamp_S;
  logic       fault;
  logic [2:0] fault_code;
  logic       mon_ok;

  modport master (
    output light_M1_in, light_M2_in, light_MT_in, light_S_in, fault_clr,
    input  lamp_M1, lamp_M2, lamp_MT, lamp_S, fault, fault_code, mon_ok
  );

  modport slave (
    input  light_M1_in, light_M2_in, light_MT_in, light_S_in, fault_clr,
    output lamp_M1, lamp_M2, lamp_MT, lamp_S, fault, fault_code, mon_ok
  );
endinterface

// File: rtl/traffic_conflict_monitor.sv
// Safety stage between the traffic light controller and the lamp drivers: registers the
// light buses, checks them, and on the first violation latches a code and flashes red.
module traffic_conflict_monitor #(
  parameter int MIN_YEL    = 2,
  parameter int MAX_HOLD   = 32,
  parameter int FLASH_HALF = 4,
  parameter int ALLRED     = 4
) (
  input logic                        clk,
  input logic                        rst,
  traffic_conflict_monitor_if.slave  bus
);

  localparam logic [2:0] C_GRN = 3'b001;
  localparam logic [2:0] C_YEL = 3'b010;
  localparam logic [2:0] C_RED = 3'b100;
  localparam logic [2:0] C_OFF = 3'b000;
  localparam logic [7:0] HOLD_LIM    = 8'(MAX_HOLD - 1);
  localparam logic [7:0] YEL_MIN     = 8'(MIN_YEL);
  localparam logic [7:0] ALLRED_LAST = 8'(ALLRED - 1);
  localparam logic [7:0] FLASH_LAST  = 8'(2 * FLASH_HALF - 1);
  localparam logic [7:0] FLASH_ON    = 8'(FLASH_HALF);

  typedef enum logic [1:0] {
    ST_INIT_RED = 2'd0,
    ST_NORMAL   = 2'd1,
    ST_FLASH    = 2'd2
  } state_t;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == C_GRN) || (v == C_YEL) || (v == C_RED);
  endfunction

  function automatic logic legal_step(input logic [2:0] p, input logic [2:0] c);
    return ((p == C_GRN) && (c == C_YEL)) ||
           ((p == C_YEL) && (c == C_RED)) ||
           ((p == C_RED) && (c == C_GRN));
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Head index: 0 = M1, 1 = M2, 2 = MT, 3 = S
  logic [2:0] w_in     [4];
  logic [2:0] r_in_q   [4];
  logic [2:0] r_prev_q [4];
  logic [2:0] r_lamp   [4];
  logic [7:0] r_hold   [4];
  logic [7:0] r_yel    [4];

  state_t     r_state;
  logic [7:0] r_init_cnt;
  logic [7:0] r_flash_cnt;
  logic       r_first;
  logic       r_fault;
  logic [2:0] r_fault_code;
  logic       r_mon_ok;

  logic       w_enc;
  logic       w_conf;
  logic       w_seq;
  logic       w_yel;
  logic       w_hold;
  logic [2:0] w_code;
  logic [7:0] w_flash_nxt;

  assign w_in[0] = bus.light_M1_in;
  assign w_in[1] = bus.light_M2_in;
  assign w_in[2] = bus.light_MT_in;
  assign w_in[3] = bus.light_S_in;

  assign bus.lamp_M1    = r_lamp[0];
  assign bus.lamp_M2    = r_lamp[1];
  assign bus.lamp_MT    = r_lamp[2];
  assign bus.lamp_S     = r_lamp[3];
  assign bus.fault      = r_fault;
  assign bus.fault_code = r_fault_code;
  assign bus.mon_ok     = r_mon_ok;

  // Input stage: current sample and the sample before it, for transition checks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int h = 0; h < 4; h++) begin
        r_in_q[h]   <= C_RED;
        r_prev_q[h] <= C_RED;
      end
    end else begin
      for (int h = 0; h < 4; h++) begin
        r_prev_q[h] <= r_in_q[h];
        r_in_q[h]   <= w_in[h];
      end
    end
  end

  // Violation detection and priority encoding; transition checks are skipped on the first NORMAL cycle
  always_comb begin
    w_enc  = 1'b0;
    w_seq  = 1'b0;
    w_yel  = 1'b0;
    w_hold = 1'b0;
    for (int h = 0; h < 4; h++) begin
      w_enc  = w_enc | ~is_onehot3(r_in_q[h]);
      w_seq  = w_seq | ((r_in_q[h] != r_prev_q[h]) & ~legal_step(r_prev_q[h], r_in_q[h]));
      w_yel  = w_yel | ((r_prev_q[h] == C_YEL) & (r_in_q[h] == C_RED) & (r_yel[h] < YEL_MIN));
      w_hold = w_hold | ((r_in_q[h] == r_prev_q[h]) & (r_hold[h] >= HOLD_LIM));
    end
    w_conf = ((r_in_q[3] != C_RED) &&
              ((r_in_q[0] != C_RED) || (r_in_q[1] != C_RED) || (r_in_q[2] != C_RED))) ||
             ((r_in_q[2] != C_RED) && (r_in_q[1] != C_RED));
    if (w_enc) begin
      w_code = 3'd1;
    end else if (w_conf) begin
      w_code = 3'd2;
    end else if (w_seq && !r_first) begin
      w_code = 3'd3;
    end else if (w_yel && !r_first) begin
      w_code = 3'd4;
    end else if (w_hold && !r_first) begin
      w_code = 3'd5;
    end else begin
      w_code = 3'd0;
    end
    if (r_flash_cnt >= FLASH_LAST) begin
      w_flash_nxt = 8'd0;
    end else begin
      w_flash_nxt = r_flash_cnt + 8'd1;
    end
  end

  // Monitor FSM with registered lamp drives, fault latch and per-head counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_INIT_RED;
      r_init_cnt   <= 8'd0;
      r_flash_cnt  <= 8'd0;
      r_first      <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_code <= 3'd0;
      r_mon_ok     <= 1'b0;
      for (int h = 0; h < 4; h++) begin
        r_lamp[h] <= C_RED;
        r_hold[h] <= 8'd0;
        r_yel[h]  <= 8'd0;
      end
    end else begin
      case (r_state)
        ST_INIT_RED: begin
          for (int h = 0; h < 4; h++) r_lamp[h] <= C_RED;
          if (r_init_cnt >= ALLRED_LAST) begin
            r_state    <= ST_NORMAL;
            r_mon_ok   <= 1'b1;
            r_first    <= 1'b1;
            r_init_cnt <= 8'd0;
          end else begin
            r_init_cnt <= r_init_cnt + 8'd1;
          end
        end
        ST_NORMAL: begin
          r_first <= 1'b0;
          if (w_code != 3'd0) begin
            // The offending sample is replaced by red so it never reaches the lamps
            for (int h = 0; h < 4; h++) r_lamp[h] <= C_RED;
            r_state      <= ST_FLASH;
            r_fault      <= 1'b1;
            r_fault_code <= w_code;
            r_mon_ok     <= 1'b0;
            r_flash_cnt  <= 8'd0;
          end else begin
            for (int h = 0; h < 4; h++) begin
              r_lamp[h] <= r_in_q[h];
              if (r_first) begin
                r_hold[h] <= 8'd0;
                r_yel[h]  <= 8'd0;
              end else begin
                r_hold[h] <= (r_in_q[h] == r_prev_q[h]) ? sat_inc(r_hold[h]) : 8'd0;
                r_yel[h]  <= (r_in_q[h] == C_YEL) ? sat_inc(r_yel[h]) : 8'd0;
              end
            end
          end
        end
        ST_FLASH: begin
          if (bus.fault_clr) begin
            for (int h = 0; h < 4; h++) r_lamp[h] <= C_RED;
            r_state      <= ST_INIT_RED;
            r_fault      <= 1'b0;
            r_fault_code <= 3'd0;
            r_init_cnt   <= 8'd0;
          end else begin
            r_flash_cnt <= w_flash_nxt;
            for (int h = 0; h < 4; h++) r_lamp[h] <= (w_flash_nxt < FLASH_ON) ? C_RED : C_OFF;
          end
        end
        default: begin
          for (int h = 0; h < 4; h++) r_lamp[h] <= C_RED;
          r_state    <= ST_INIT_RED;
          r_init_cnt <= 8'd0;
          r_mon_ok   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed self-checking bench for traffic_conflict_monitor: legal run, each fault code,
// the flashing failsafe, fault clear and asynchronous reset.
module tb_traffic_conflict_monitor;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;
  localparam logic [11:0] ALL_RED = 12'h924;
  localparam logic [11:0] ALL_OFF = 12'h000;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  traffic_conflict_monitor_if bus ();

  traffic_conflict_monitor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [11:0] lamps();
    return {bus.lamp_M1, bus.lamp_M2, bus.lamp_MT, bus.lamp_S};
  endfunction

  // Legal 28-step controller cycle, {M1, M2, MT, S}
  function automatic logic [11:0] legal(input int k);
    int p;
    p = k % 28;
    if (p < 8)       return {G, G, R, R};
    else if (p < 10) return {Y, Y, R, R};
    else if (p < 16) return {R, R, G, R};
    else if (p < 18) return {R, R, Y, R};
    else if (p < 24) return {R, R, R, G};
    else if (p < 26) return {R, R, R, Y};
    else             return {R, R, R, R};
  endfunction

  task automatic set_lights(input logic [11:0] v);
    {bus.light_M1_in, bus.light_M2_in, bus.light_MT_in, bus.light_S_in} = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset with all-red inputs and run through INIT_RED and the first NORMAL edge (edge 5)
  task automatic reset_to_normal();
    step();
    rst = 1'b1;
    bus.fault_clr = 1'b0;
    set_lights(ALL_RED);
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.fault_clr = 1'b0;
    set_lights(ALL_RED);
    #2;
    n_tests++;
    if (lamps() !== ALL_RED) begin
      n_fail++; $display("FAIL reset_lamps: got %h want %h", lamps(), ALL_RED);
    end
    n_tests++;
    if ({bus.fault, bus.fault_code, bus.mon_ok} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want %b", {bus.fault, bus.fault_code, bus.mon_ok}, 5'b0);
    end
  endtask

  task automatic test_legal_run();
    logic [11:0] exp;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_lights(legal(0));
    for (int n = 1; n <= 86; n++) begin
      step();
      exp = (n <= 4) ? ALL_RED : legal(n - 2);
      n_tests++;
      if (lamps() !== exp) begin
        n_fail++; $display("FAIL legal_lamps edge %0d: got %h want %h", n, lamps(), exp);
      end
      n_tests++;
      if (bus.fault !== 1'b0 || bus.mon_ok !== (n >= 4)) begin
        n_fail++; $display("FAIL legal_flags edge %0d: got fault=%b mon_ok=%b want fault=0 mon_ok=%b",
                           n, bus.fault, bus.mon_ok, (n >= 4));
      end
      set_lights(legal(n));
    end
  endtask

  task automatic test_conflict_flash();
    logic [11:0] exp;
    reset_to_normal();
    set_lights({G, R, R, G});
    step();
    n_tests++;
    if (lamps() !== ALL_RED) begin
      n_fail++; $display("FAIL conflict_pre: got %h want %h", lamps(), ALL_RED);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      exp = ((i % 8) < 4) ? ALL_RED : ALL_OFF;
      n_tests++;
      if (lamps() !== exp) begin
        n_fail++; $display("FAIL flash_lamps %0d: got %h want %h", i, lamps(), exp);
      end
      n_tests++;
      if (bus.fault !== 1'b1 || bus.fault_code !== 3'd2 || bus.mon_ok !== 1'b0) begin
        n_fail++; $display("FAIL conflict_code %0d: got fault=%b code=%0d ok=%b want 1 2 0",
                           i, bus.fault, bus.fault_code, bus.mon_ok);
      end
    end
  endtask

  task automatic test_enc_priority();
    reset_to_normal();
    set_lights({R, 3'b011, G, R});
    step();
    step();
    n_tests++;
    if (bus.fault !== 1'b1 || bus.fault_code !== 3'd1 || lamps() !== ALL_RED) begin
      n_fail++; $display("FAIL enc_priority: got fault=%b code=%0d lamps=%h want 1 1 %h",
                         bus.fault, bus.fault_code, lamps(), ALL_RED);
    end
  endtask

  task automatic test_seq_and_yel();
    reset_to_normal();
    set_lights({G, R, R, R});
    step();
    set_lights({R, R, R, R});
    step();
    n_tests++;
    if (bus.fault !== 1'b0 || lamps() !== 12'h324) begin
      n_fail++; $display("FAIL seq_pre: got fault=%b lamps=%h want 0 324", bus.fault, lamps());
    end
    step();
    n_tests++;
    if (bus.fault !== 1'b1 || bus.fault_code !== 3'd3 || lamps() !== ALL_RED) begin
      n_fail++; $display("FAIL seq_code: got fault=%b code=%0d lamps=%h want 1 3 %h",
                         bus.fault, bus.fault_code, lamps(), ALL_RED);
    end
    reset_to_normal();
    set_lights({G, R, R, R});
    step();
    set_lights({Y, R, R, R});
    step();
    set_lights({R, R, R, R});
    step();
    n_tests++;
    if (bus.fault !== 1'b0 || lamps() !== 12'h524) begin
      n_fail++; $display("FAIL yel_pre: got fault=%b lamps=%h want 0 524", bus.fault, lamps());
    end
    step();
    n_tests++;
    if (bus.fault !== 1'b1 || bus.fault_code !== 3'd4 || lamps() !== ALL_RED) begin
      n_fail++; $display("FAIL yel_code: got fault=%b code=%0d lamps=%h want 1 4 %h",
                         bus.fault, bus.fault_code, lamps(), ALL_RED);
    end
  endtask

  task automatic test_hold();
    reset_to_normal();
    for (int i = 0; i < 31; i++) step();
    n_tests++;
    if (bus.fault !== 1'b0 || bus.mon_ok !== 1'b1) begin
      n_fail++; $display("FAIL hold_31: got fault=%b ok=%b want 0 1", bus.fault, bus.mon_ok);
    end
    step();
    n_tests++;
    if (bus.fault !== 1'b1 || bus.fault_code !== 3'd5 || lamps() !== ALL_RED) begin
      n_fail++; $display("FAIL hold_32: got fault=%b code=%0d lamps=%h want 1 5 %h",
                         bus.fault, bus.fault_code, lamps(), ALL_RED);
    end
  endtask

  task automatic test_clear_and_async_reset();
    reset_to_normal();
    set_lights({G, R, R, G});
    step();
    step();
    set_lights(ALL_RED);
    step();
    bus.fault_clr = 1'b1;
    step();
    bus.fault_clr = 1'b0;
    n_tests++;
    if (bus.fault !== 1'b0 || bus.fault_code !== 3'd0 || lamps() !== ALL_RED || bus.mon_ok !== 1'b0) begin
      n_fail++; $display("FAIL clear: got fault=%b code=%0d lamps=%h ok=%b want 0 0 %h 0",
                         bus.fault, bus.fault_code, lamps(), bus.mon_ok, ALL_RED);
    end
    for (int i = 0; i < 3; i++) step();
    n_tests++;
    if (bus.mon_ok !== 1'b0 || lamps() !== ALL_RED) begin
      n_fail++; $display("FAIL clear_allred: got ok=%b lamps=%h want 0 %h", bus.mon_ok, lamps(), ALL_RED);
    end
    step();
    n_tests++;
    if (bus.mon_ok !== 1'b1 || lamps() !== ALL_RED) begin
      n_fail++; $display("FAIL clear_normal: got ok=%b lamps=%h want 1 %h", bus.mon_ok, lamps(), ALL_RED);
    end
    bus.fault_clr = 1'b1;
    set_lights({G, R, R, G});
    step();
    bus.fault_clr = 1'b0;
    n_tests++;
    if (bus.mon_ok !== 1'b1 || bus.fault !== 1'b0) begin
      n_fail++; $display("FAIL clr_ignored: got ok=%b fault=%b want 1 0", bus.mon_ok, bus.fault);
    end
    for (int i = 0; i < 5; i++) step();
    n_tests++;
    if (lamps() !== ALL_OFF || bus.fault !== 1'b1) begin
      n_fail++; $display("FAIL flash_off: got lamps=%h fault=%b want %h 1", lamps(), bus.fault, ALL_OFF);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (lamps() !== ALL_RED || bus.fault !== 1'b0 || bus.fault_code !== 3'd0 || bus.mon_ok !== 1'b0) begin
      n_fail++; $display("FAIL async_rst: got lamps=%h fault=%b code=%0d ok=%b want %h 0 0 0",
                         lamps(), bus.fault, bus.fault_code, bus.mon_ok, ALL_RED);
    end
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_legal_run();
    test_conflict_flash();
    test_enc_priority();
    test_seq_and_yel();
    test_hold();
    test_clear_and_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
